// File: rtl/mult_iterate_param_if.sv
// mult_iterate_param_if: start/busy/done handshake and operand/product bus of the iterative multiplier
interface mult_iterate_param_if #(
    parameter int NBITS = 16,
    parameter int NTAPS = 25
);
    logic                        start;
    logic [NTAPS-1:0][NBITS-1:0] A;
    logic [NTAPS-1:0][NBITS-1:0] B;
    logic [NTAPS-1:0][NBITS-1:0] P;
    logic                        busy;
    logic                        done;

    modport master (output start, A, B, input P, busy, done);
    modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/mult_iterate_param.sv
// mult_iterate_param: P[i] = (A[i]*B[i]) >>> QUANT over NTAPS pairs using LANES multipliers in ceil(NTAPS/LANES) passes.
// Define MULT_ITERATE_SAT_EN to saturate results to the signed NBITS range instead of wrapping.
module mult_iterate_param #(
    parameter int NBITS = 16,
    parameter int QUANT = 8,
    parameter int NTAPS = 25,
    parameter int LANES = 5
) (
    input logic                 clk,
    input logic                 reset,
    mult_iterate_param_if.slave bus
);
    localparam int NPASS = (NTAPS + LANES - 1) / LANES;
    localparam int PW = NPASS > 1 ? $clog2(NPASS) : 1;
`ifdef MULT_ITERATE_SAT_EN
    localparam logic signed [2*NBITS-1:0] PMAX = {{(NBITS + 1){1'b0}}, {(NBITS - 1){1'b1}}};
    localparam logic signed [2*NBITS-1:0] PMIN = ~PMAX;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state;
    logic [PW-1:0]               pass;
    logic [NTAPS-1:0][NBITS-1:0] a_q;
    logic [NTAPS-1:0][NBITS-1:0] b_q;
    logic [LANES-1:0][NBITS-1:0] lane_a;
    logic [LANES-1:0][NBITS-1:0] lane_b;
    logic [LANES-1:0][NBITS-1:0] lane_res;

    function automatic logic [NBITS-1:0] qmul(input logic signed [NBITS-1:0] x, input logic signed [NBITS-1:0] y);
        logic signed [2*NBITS-1:0] f;
        f = (x * y) >>> QUANT;
`ifdef MULT_ITERATE_SAT_EN
        return f > PMAX ? PMAX[NBITS-1:0] : f < PMIN ? PMIN[NBITS-1:0] : f[NBITS-1:0];
`else
        return f[NBITS-1:0];
`endif
    endfunction

    // Tap i always belongs to lane i%LANES of pass i/LANES; lanes past NTAPS in the last pass have no tap.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < NTAPS; i++)
            if (pass == PW'(i / LANES)) begin
                lane_a[i % LANES] = a_q[i];
                lane_b[i % LANES] = b_q[i];
            end
    end

    always_comb begin
        lane_res = '0;
        for (int l = 0; l < LANES; l++)
            lane_res[l] = qmul(lane_a[l], lane_b[l]);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            pass     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bus.P    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a_q      <= bus.A;
                    b_q      <= bus.B;
                    pass     <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
            end else begin
                for (int i = 0; i < NTAPS; i++)
                    if (pass == PW'(i / LANES))
                        bus.P[i] <= lane_res[i % LANES];
                if (pass == PW'(NPASS - 1)) begin
                    pass     <= '0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end else
                    pass <= pass + 1'b1;
            end
        end
endmodule

// File: tb/tb_mult_iterate_param.sv
// tb_mult_iterate_param: randomized checks of the default (5-lane) and a 4-lane build against an arithmetic reference model.
module tb_mult_iterate_param;
    localparam int NB = 16;
    localparam int Q = 8;
    localparam int NT = 25;

    typedef logic [NT-1:0][NB-1:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    mult_iterate_param_if #(.NBITS(NB), .NTAPS(NT)) d_bus();
    mult_iterate_param_if #(.NBITS(NB), .NTAPS(NT)) q_bus();

    mult_iterate_param d_dut (.clk(clk), .reset(reset), .bus(d_bus));
    mult_iterate_param #(.LANES(4)) q_dut (.clk(clk), .reset(reset), .bus(q_bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] ref_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
        longint f;
        longint lim;
        lim = longint'(1) << (NB - 1);
        f = (longint'($signed(a)) * longint'($signed(b))) >>> Q;
`ifdef MULT_ITERATE_SAT_EN
        if (f > lim - 1) f = lim - 1;
        else if (f < -lim) f = -lim;
`endif
        return NB'(f);
    endfunction

    function automatic vec_t ref_vec(input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < NT; i++) r[i] = ref_mul(a[i], b[i]);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < NT; i++) r[i] = NB'($urandom);
        return r;
    endfunction

    task automatic do_op(input bit sel, input vec_t a, input vec_t b, output int lat, output int bc, output vec_t p);
        if (sel) begin
            q_bus.start = 1'b1; q_bus.A = a; q_bus.B = b;
        end else begin
            d_bus.start = 1'b1; d_bus.A = a; d_bus.B = b;
        end
        tick();
        q_bus.start = 1'b0;
        d_bus.start = 1'b0;
        lat = 0;
        bc = int'(sel ? q_bus.busy : d_bus.busy);
        while (!(sel ? q_bus.done : d_bus.done) && lat < 30) begin
            tick();
            lat++;
            if (!(sel ? q_bus.done : d_bus.done) && (sel ? q_bus.busy : d_bus.busy)) bc++;
        end
        p = sel ? q_bus.P : d_bus.P;
    endtask

    task automatic test_reset();
        d_bus.start = 1'b0; d_bus.A = '0; d_bus.B = '0;
        q_bus.start = 1'b0; q_bus.A = '0; q_bus.B = '0;
        #2 reset = 1'b0;
        repeat (2) tick();
        n_chk++; if (d_bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", d_bus.busy); end
        n_chk++; if (d_bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", d_bus.done); end
        n_chk++; if (d_bus.P !== '0) begin n_fail++; $display("FAIL reset_P got %h want 0", d_bus.P); end
        n_chk++; if (q_bus.busy !== 1'b0 || q_bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_q_hs got %b%b want 00", q_bus.busy, q_bus.done); end
        n_chk++; if (q_bus.P !== '0) begin n_fail++; $display("FAIL reset_q_P got %h want 0", q_bus.P); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        vec_t a, b, p, exp;
        int lat, bc;
        for (int i = 0; i < NT; i++) begin
            a[i] = 16'h0200; b[i] = 16'h0180; exp[i] = 16'h0300;
        end
        do_op(1'b0, a, b, lat, bc, p);
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
        n_chk++; if (bc !== 5) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
        n_chk++; if (d_bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", d_bus.busy); end
        n_chk++; if (p !== exp) begin n_fail++; $display("FAIL basic_P got %h want %h", p, exp); end
        tick();
        n_chk++; if (d_bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", d_bus.done); end
    endtask

    task automatic test_single();
        vec_t a, b, p, exp;
        int lat, bc;
        a = '0; b = '0; exp = '0;
        a[3] = 16'hFF00; b[3] = 16'h0080; exp[3] = 16'hFF80;
        do_op(1'b0, a, b, lat, bc, p);
        n_chk++; if (p !== exp) begin n_fail++; $display("FAIL single_neg_P got %h want %h", p, exp); end
    endtask

    task automatic test_sat();
        vec_t a, b, p, exp;
        int lat, bc;
        a = '0; b = '0; exp = '0;
        a[0] = 16'h7FFF; b[0] = 16'h7FFF;
`ifdef MULT_ITERATE_SAT_EN
        exp[0] = 16'h7FFF;
`else
        exp[0] = 16'hFF00;
`endif
        do_op(1'b0, a, b, lat, bc, p);
        n_chk++; if (p !== exp) begin n_fail++; $display("FAIL sat_pos_P got %h want %h", p, exp); end
        a[0] = 16'h8000;
`ifdef MULT_ITERATE_SAT_EN
        exp[0] = 16'h8000;
`else
        exp[0] = 16'h0080;
`endif
        do_op(1'b0, a, b, lat, bc, p);
        n_chk++; if (p !== exp) begin n_fail++; $display("FAIL sat_neg_P got %h want %h", p, exp); end
    endtask

    task automatic test_random();
        vec_t a, b, p, exp;
        int lat, bc;
        for (int k = 0; k < 4; k++) begin
            a = rand_vec(); b = rand_vec();
            exp = ref_vec(a, b);
            do_op(1'b0, a, b, lat, bc, p);
            n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL random_latency[%0d] got %0d want 5", k, lat); end
            n_chk++; if (p !== exp) begin n_fail++; $display("FAIL random_P[%0d] got %h want %h", k, p, exp); end
        end
    endtask

    task automatic test_lanes4();
        vec_t a, b, p, exp;
        int lat, bc;
        for (int i = 0; i < NT; i++) begin
            a[i] = NB'(i << 8); b[i] = 16'h0100;
        end
        do_op(1'b1, a, b, lat, bc, p);
        n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL lanes4_latency got %0d want 7", lat); end
        n_chk++; if (bc !== 7) begin n_fail++; $display("FAIL lanes4_busy_cycles got %0d want 7", bc); end
        n_chk++; if (p !== a) begin n_fail++; $display("FAIL lanes4_P got %h want %h", p, a); end
        n_chk++; if (p[24] !== 16'h1800) begin n_fail++; $display("FAIL lanes4_last_tap got %h want 1800", p[24]); end
        for (int k = 0; k < 2; k++) begin
            a = rand_vec(); b = rand_vec();
            exp = ref_vec(a, b);
            do_op(1'b1, a, b, lat, bc, p);
            n_chk++; if (p !== exp) begin n_fail++; $display("FAIL lanes4_random_P[%0d] got %h want %h", k, p, exp); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t a1, b1, a2, b2, exp;
        int lat;
        a1 = rand_vec(); b1 = rand_vec();
        a2 = rand_vec(); b2 = rand_vec();
        d_bus.start = 1'b1; d_bus.A = a1; d_bus.B = b1;
        tick();
        d_bus.start = 1'b0;
        tick();
        d_bus.start = 1'b1; d_bus.A = a2; d_bus.B = b2;
        tick();
        tick();
        d_bus.start = 1'b0; d_bus.A = rand_vec(); d_bus.B = rand_vec();
        lat = 3;
        while (!d_bus.done && lat < 30) begin tick(); lat++; end
        exp = ref_vec(a1, b1);
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL ignore_latency got %0d want 5", lat); end
        n_chk++; if (d_bus.P !== exp) begin n_fail++; $display("FAIL ignore_P got %h want %h", d_bus.P, exp); end
        d_bus.start = 1'b1; d_bus.A = a2; d_bus.B = b2;
        tick();
        d_bus.start = 1'b0;
        n_chk++; if (d_bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", d_bus.busy); end
        lat = 0;
        while (!d_bus.done && lat < 30) begin tick(); lat++; end
        exp = ref_vec(a2, b2);
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency got %0d want 5", lat); end
        n_chk++; if (d_bus.P !== exp) begin n_fail++; $display("FAIL b2b_P got %h want %h", d_bus.P, exp); end
    endtask

    task automatic test_reset_mid();
        vec_t a, b, p, exp;
        int lat, bc, seen;
        a = rand_vec(); b = rand_vec();
        d_bus.start = 1'b1; d_bus.A = a; d_bus.B = b;
        tick();
        d_bus.start = 1'b0;
        tick();
        tick();
        #1 reset = 1'b0;
        #1;
        n_chk++; if (d_bus.busy !== 1'b0 || d_bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_hs got busy %b done %b want 0 0", d_bus.busy, d_bus.done); end
        n_chk++; if (d_bus.P !== '0) begin n_fail++; $display("FAIL midreset_P got %h want 0", d_bus.P); end
        seen = 0;
        repeat (3) begin tick(); if (d_bus.done) seen++; end
        reset = 1'b1;
        repeat (8) begin tick(); if (d_bus.done || d_bus.busy) seen++; end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done got %0d activity cycles want 0", seen); end
        a = rand_vec(); b = rand_vec();
        exp = ref_vec(a, b);
        do_op(1'b0, a, b, lat, bc, p);
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL postreset_latency got %0d want 5", lat); end
        n_chk++; if (p !== exp) begin n_fail++; $display("FAIL postreset_P got %h want %h", p, exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_sat();
        test_random();
        test_lanes4();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
